// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// A single valid/ready input stream is steered word by word to one of two
// output streams by in_sel. Each output has its own DEPTH-entry FIFO, so a
// stalled consumer only blocks input words that are routed to it.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        input handshake (in_ready depends on in_sel)
//   in_data, in_sel          input word and destination (0 = out0, 1 = out1)
//   outN_valid/outN_ready    output handshake per destination
//   outN_data                head of the destination FIFO (registered storage)
//   cnt0, cnt1               words accepted toward each output, wrapping
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_OCC = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [AW:0]      wr_ptr [2];
  logic [AW:0]      rd_ptr [2];
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [CNT_W-1:0] cnt    [2];

  logic [AW:0] occ [2];
  logic [1:0]  full;
  logic [1:0]  valid;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  rdy;

  assign rdy = {out1_ready, out0_ready};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      occ[i]   = wr_ptr[i] - rd_ptr[i];
      full[i]  = (occ[i] == FULL_OCC);
      valid[i] = (occ[i] != '0);
    end
  end

  // No pop-through: a full FIFO refuses the word even if it drains this cycle.
  assign in_ready = !full[in_sel];

  always_comb begin
    push = 2'b00;
    if (in_valid && in_ready) begin
      push = in_sel ? 2'b10 : 2'b01;
    end
  end

  assign pop = valid & rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i][AW-1:0]] <= in_data;
          wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          cnt[i]    <= cnt[i] + CNT_ONE;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        end
      end
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem[0][rd_ptr[0][AW-1:0]];
  assign out1_data  = mem[1][rd_ptr[1][AW-1:0]];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: queue-based reference model of the two output
// FIFOs and counters, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized traffic phase.
module tb_demux2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per output, wrapping counters, pop log.
  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] log0[$], log1[$];
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  logic             stalled;
  logic             m_acc, m_p0, m_p1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete(); q1.delete(); log0.delete(); log1.delete();
      m_cnt0 = '0; m_cnt1 = '0; stalled = 1'b0;
    end else begin
      m_p0  = (q0.size() != 0) && out0_ready;
      m_p1  = (q1.size() != 0) && out1_ready;
      m_acc = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      stalled = in_valid && !m_acc;
      if (m_p0) log0.push_back(q0.pop_front());
      if (m_p1) log1.push_back(q1.pop_front());
      if (m_acc) begin
        if (in_sel) begin q1.push_back(in_data); m_cnt1 = m_cnt1 + 1'b1; end
        else        begin q0.push_back(in_data); m_cnt0 = m_cnt0 + 1'b1; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      chk("out0_valid", out0_valid, q0.size() != 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic s);
    in_valid = 1'b1; in_data = d; in_sel = s;
    step();
  endtask

  initial begin
    int n;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_cnt", {cnt1, cnt0}, 0);

    // 1: single route
    step();
    out0_ready = 1'b1;
    push(8'hA5, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out0_valid", out0_valid, 1);
    chk("t1_out0_data", out0_data, 8'hA5);
    chk("t1_cnt0", cnt0, 1);
    chk("t1_cnt1", cnt1, 0);
    chk("t1_out1_valid", out1_valid, 0);

    // 2: alternating routing
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); in_sel = i[0];
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("t2_log0", {log0.size() == 2 ? 1'b1 : 1'b0, log0[0], log0[1]}, {1'b1, 8'h01, 8'h03});
    chk("t2_log1", {log1.size() == 2 ? 1'b1 : 1'b0, log1[0], log1[1]}, {1'b1, 8'h02, 8'h04});
    chk("t2_cnt", {cnt1, cnt0}, {4'd2, 4'd2});

    // 3: backpressure and full
    do_reset();
    push(8'h10, 1'b0);
    push(8'h11, 1'b0);
    in_valid = 1'b1; in_data = 8'h12; in_sel = 1'b0;
    @(negedge clk);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_hold_data_a", out0_data, 8'h10);
    step();
    @(negedge clk);
    chk("t3_still_full", in_ready, 0);
    chk("t3_hold_data_b", out0_data, 8'h10);
    step();
    in_data = 8'h20; in_sel = 1'b1;
    @(negedge clk);
    chk("t3_other_ready", in_ready, 1);
    step();
    in_data = 8'h12; in_sel = 1'b0; out0_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      step(); @(negedge clk); guard++;
    end
    chk("t3_timeout", guard < 20, 1);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("t3_log0", {log0.size() == 3 ? 1'b1 : 1'b0, log0[0], log0[1], log0[2]},
        {1'b1, 8'h10, 8'h11, 8'h12});
    chk("t3_q1_head", (q1.size() == 1) ? q1[0] : 8'hFF, 8'h20);

    // 4: simultaneous push and pop
    do_reset();
    push(8'h30, 1'b0);
    out0_ready = 1'b1;
    push(8'h31, 1'b0);
    in_valid = 1'b0; out0_ready = 1'b0;
    @(negedge clk);
    chk("t4_valid", out0_valid, 1);
    chk("t4_data", out0_data, 8'h31);
    chk("t4_occ", q0.size(), 1);
    chk("t4_popped", log0[0], 8'h30);

    // 5: counter wrap (CNT_W = 4)
    do_reset();
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1;
    n = 0; guard = 0;
    while (n < 17 && guard < 100) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (in_ready) n++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_count_done", n, 17);
    chk("t5_cnt1", cnt1, 1);
    chk("t5_cnt0", cnt0, 0);

    // 6: async reset mid-operation
    do_reset();
    push(8'h40, 1'b0); push(8'h41, 1'b0);
    push(8'h42, 1'b1); push(8'h43, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_out0_valid", out0_valid, 0);
    chk("t6_out1_valid", out1_valid, 0);
    chk("t6_cnt", {cnt1, cnt0}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    in_sel = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 1);
    step();
    push(8'h55, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_out1", {out1_valid, out1_data}, {1'b1, 8'h55});
    chk("t6_out0_valid_after", out0_valid, 0);

    // Randomized traffic; producer holds a stalled word stable.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom);
        in_data  = 8'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
